// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: NUM_SRC-source external interrupt controller with claim/complete over the IOBUS.
// Optional feature macro OTTER_INTC_EDGE_EN adds the EDGE register and edge-triggered pending.
module otter_intr_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter int          PRIO_W    = 3,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_in_i,
    input  logic [31:0]        iobus_addr_i,
    input  logic               iobus_wr_i,
    input  logic               iobus_rd_i,
    input  logic [31:0]        iobus_out_i,
    output logic [31:0]        iobus_in_o,
    output logic               intc_sel_o,
    output logic               m_ext_int_o
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] inService_q, inService_d;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] eligible;
    logic [PRIO_W-1:0]  threshold_q;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [PRIO_W-1:0]  bestPrio;
    logic [5:0]         bestId;
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q;
    logic [7:0]         offset;
    logic               regWr, regRd, claimHit, completeHit;
    logic [5:0]         completeId;
    logic               unusedData;
`ifdef OTTER_INTC_EDGE_EN
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] src_q;
`endif

    assign intc_sel_o  = (iobus_addr_i[31:8] == BASE_ADDR[31:8]);
    assign offset      = iobus_addr_i[7:0];
    assign regWr       = iobus_wr_i & intc_sel_o;
    assign regRd       = iobus_rd_i & intc_sel_o;
    assign claimHit    = regRd & (offset == 8'h0C);
    assign completeHit = regWr & (offset == 8'h0C);
    assign completeId  = iobus_out_i[5:0];
    assign unusedData  = ^iobus_out_i;
    assign iobus_in_o  = rdata_q;
    assign m_ext_int_o = irq_q;

    // Strict '>' while scanning upward keeps the lowest index on a priority tie.
    always_comb begin
        eligible = '0;
        bestId   = '0;
        bestPrio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & ~inService_q[i] & (prio_q[i] > threshold_q);
            if (eligible[i] && (prio_q[i] > bestPrio)) begin
                bestPrio = prio_q[i];
                bestId   = 6'(i + 1);
            end
        end
    end

    // A claim is applied after the source update so it wins over a same-cycle assertion.
    always_comb begin
`ifdef OTTER_INTC_EDGE_EN
        pending_d = (edge_q & (pending_q | (src_in_i & ~src_q)))
                  | (~edge_q & src_in_i & ~inService_q);
`else
        pending_d = src_in_i & ~inService_q;
`endif
        inService_d = inService_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (completeHit && (completeId == 6'(i + 1))) begin
                inService_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claimHit && (bestId == 6'(i + 1))) begin
                inService_d[i] = 1'b1;
                pending_d[i]   = 1'b0;
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (regRd) begin
            rdata_d = '0;
            case (offset)
                8'h00: rdata_d = 32'(pending_q);
                8'h04: rdata_d = 32'(enable_q);
                8'h08: rdata_d = 32'(threshold_q);
                8'h0C: rdata_d = 32'(bestId);
`ifdef OTTER_INTC_EDGE_EN
                8'h10: rdata_d = 32'(edge_q);
`endif
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (offset == 8'(32 + 4 * i)) begin
                            rdata_d = 32'(prio_q[i]);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            inService_q <= '0;
            enable_q    <= '0;
            threshold_q <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
`ifdef OTTER_INTC_EDGE_EN
            edge_q <= '0;
            src_q  <= '0;
`endif
        end else begin
            pending_q   <= pending_d;
            inService_q <= inService_d;
            rdata_q     <= rdata_d;
            irq_q       <= |eligible;
            if (regWr && (offset == 8'h04)) begin
                enable_q <= iobus_out_i[NUM_SRC-1:0];
            end
            if (regWr && (offset == 8'h08)) begin
                threshold_q <= iobus_out_i[PRIO_W-1:0];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (regWr && (offset == 8'(32 + 4 * i))) begin
                    prio_q[i] <= iobus_out_i[PRIO_W-1:0];
                end
            end
`ifdef OTTER_INTC_EDGE_EN
            if (regWr && (offset == 8'h10)) begin
                edge_q <= iobus_out_i[NUM_SRC-1:0];
            end
            src_q <= src_in_i;
`endif
        end
    end

endmodule
